// File: rtl/fpu_divider16_if.sv
// Request/result bundle for the FP16 mantissa divider.
// The requester drives the operands and start pulse; the divider returns
// quotient, remainder, sticky, divide-by-zero flag and busy/done status.
interface fpu_divider16_if #(
   parameter int FRACW = 10
);
   localparam int MW = FRACW + 1;
   localparam int QW = 2 * MW;

   logic          start;
   logic [MW-1:0] divIn1;
   logic [MW-1:0] divIn2;
   logic [QW-1:0] quotOut;
   logic [MW-1:0] remOut;
   logic          sticky;
   logic          divZero;
   logic          busy;
   logic          done;

   modport master (
      output start, divIn1, divIn2,
      input  quotOut, remOut, sticky, divZero, busy, done
   );

   modport slave (
      input  start, divIn1, divIn2,
      output quotOut, remOut, sticky, divZero, busy, done
   );
endinterface

// File: rtl/fpu_divider16.sv
// Sequential unsigned restoring divider for FP16 mantissas.
// Computes (divIn1 << MW) / divIn2, retiring one quotient bit per clock,
// and returns quotient, remainder and a sticky bit for rounding.
module fpu_divider16 #(
   parameter int FRACW = 10
) (
   input  logic           clock,
   input  logic           resetN,
   fpu_divider16_if.slave bus
);
   localparam int MW = FRACW + 1;
   localparam int QW = 2 * MW;
   localparam int CW = $clog2(QW);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COMP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [QW-1:0] dvd_q;     // dividend shift register, MSB feeds the trial
   logic [MW-1:0] dvs_q;     // latched divisor
   logic [MW-1:0] rem_q;     // partial remainder
   logic [QW-1:0] quot_q;
   logic [CW-1:0] cnt_q;
   logic          sticky_q;
   logic          dz_q;

   logic [MW:0]   trial_d;
   logic          ge_d;
   logic [MW-1:0] diff_d;
   logic [MW-1:0] rem_d;
   logic          sticky_d;

   // One restoring step: trial remainder, compare, conditional subtract.
   always_comb begin
      trial_d = {rem_q, dvd_q[QW-1]};
      ge_d    = (trial_d >= {1'b0, dvs_q});
      // When trial >= divisor the true difference is below the divisor and
      // fits in MW bits, so the subtract can drop the top bit safely.
      diff_d  = trial_d[MW-1:0] - dvs_q;
      if (ge_d) begin
         rem_d = diff_d;
      end else begin
         rem_d = trial_d[MW-1:0];
      end
      sticky_d = |rem_d;
   end

   // Control FSM and datapath registers; busy/done decode from state.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q  <= S_IDLE;
         dvd_q    <= {QW{1'b0}};
         dvs_q    <= {MW{1'b0}};
         rem_q    <= {MW{1'b0}};
         quot_q   <= {QW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         sticky_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  dvd_q    <= {bus.divIn1, {MW{1'b0}}};
                  dvs_q    <= bus.divIn2;
                  rem_q    <= {MW{1'b0}};
                  cnt_q    <= {CW{1'b0}};
                  sticky_q <= 1'b0;
                  if (bus.divIn2 == {MW{1'b0}}) begin
                     quot_q  <= {QW{1'b1}};
                     dz_q    <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     quot_q  <= {QW{1'b0}};
                     dz_q    <= 1'b0;
                     state_q <= S_COMP;
                  end
               end else begin
                  state_q <= state_q;
               end
            end
            S_COMP: begin
               dvd_q    <= {dvd_q[QW-2:0], 1'b0};
               rem_q    <= rem_d;
               quot_q   <= {quot_q[QW-2:0], ge_d};
               sticky_q <= sticky_d;
               cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(QW-1)) begin
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_COMP;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.quotOut = quot_q;
   assign bus.remOut  = rem_q;
   assign bus.sticky  = sticky_q;
   assign bus.divZero = dz_q;
   assign bus.busy    = (state_q == S_COMP);
   assign bus.done    = (state_q == S_DONE);
endmodule

// File: tb/tb_fpu_divider16.sv
// Directed testbench for fpu_divider16 with hand-computed expected values.
module tb_fpu_divider16;
   logic clock;
   logic resetN;
   int   vectors;
   int   errors;
   int   n;
   int   busy_cnt;

   fpu_divider16_if #(.FRACW(10)) bus ();

   fpu_divider16 #(.FRACW(10)) dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Apply operands at a falling edge and hold start across one rising edge.
   task automatic start_op(input logic [10:0] a, input logic [10:0] b);
      @(negedge clock);
      bus.divIn1 = a;
      bus.divIn2 = b;
      bus.start  = 1'b1;
      @(negedge clock);
      bus.start  = 1'b0;
   endtask

   // Count rising edges after the start edge until done (bounded).
   task automatic wait_done();
      n        = 0;
      busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
      while (bus.done !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
         if (bus.busy === 1'b1) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      resetN     = 1'b0;
      bus.start  = 1'b0;
      bus.divIn1 = 11'd0;
      bus.divIn2 = 11'd0;
      #12;
      vectors++;
      if ({bus.quotOut, bus.remOut, bus.sticky, bus.divZero, bus.busy, bus.done} !== 36'd0) begin
         $display("FAIL reset_outputs: got q=%h r=%h s=%b z=%b b=%b d=%b, want all 0",
                  bus.quotOut, bus.remOut, bus.sticky, bus.divZero, bus.busy, bus.done);
         errors++;
      end
      @(negedge clock);
      resetN = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_basic();
      start_op(11'd1024, 11'd1024);
      wait_done();
      vectors++;
      if (n !== 22) begin $display("FAIL lat_1024_1024: got %0d want 22", n); errors++; end
      vectors++;
      if (busy_cnt !== 22) begin $display("FAIL busy_len: got %0d want 22", busy_cnt); errors++; end
      vectors++;
      if (bus.quotOut !== 22'd2048 || bus.remOut !== 11'd0 || bus.sticky !== 1'b0 || bus.divZero !== 1'b0) begin
         $display("FAIL res_1024_1024: got q=%0d r=%0d s=%b z=%b want q=2048 r=0 s=0 z=0",
                  bus.quotOut, bus.remOut, bus.sticky, bus.divZero);
         errors++;
      end
      start_op(11'd2047, 11'd1024);
      wait_done();
      vectors++;
      if (n !== 22 || bus.quotOut !== 22'd4094 || bus.remOut !== 11'd0 || bus.sticky !== 1'b0) begin
         $display("FAIL res_2047_1024: got n=%0d q=%0d r=%0d s=%b want n=22 q=4094 r=0 s=0",
                  n, bus.quotOut, bus.remOut, bus.sticky);
         errors++;
      end
      start_op(11'd1024, 11'd2047);
      wait_done();
      vectors++;
      if (n !== 22 || bus.quotOut !== 22'd1024 || bus.remOut !== 11'd1024 || bus.sticky !== 1'b1) begin
         $display("FAIL res_1024_2047: got n=%0d q=%0d r=%0d s=%b want n=22 q=1024 r=1024 s=1",
                  n, bus.quotOut, bus.remOut, bus.sticky);
         errors++;
      end
      // Unnormalized operands: (3<<11)/7 = 877 rem 5
      start_op(11'd3, 11'd7);
      wait_done();
      vectors++;
      if (bus.quotOut !== 22'd877 || bus.remOut !== 11'd5 || bus.sticky !== 1'b1) begin
         $display("FAIL res_3_7: got q=%0d r=%0d s=%b want q=877 r=5 s=1",
                  bus.quotOut, bus.remOut, bus.sticky);
         errors++;
      end
      // Largest quotient: (2047<<11)/1 = 4192256
      start_op(11'd2047, 11'd1);
      wait_done();
      vectors++;
      if (bus.quotOut !== 22'd4192256 || bus.remOut !== 11'd0) begin
         $display("FAIL res_2047_1: got q=%0d r=%0d want q=4192256 r=0", bus.quotOut, bus.remOut);
         errors++;
      end
      // Result holds in DONE
      repeat (5) @(negedge clock);
      vectors++;
      if (bus.done !== 1'b1 || bus.quotOut !== 22'd4192256) begin
         $display("FAIL done_hold: got d=%b q=%0d want d=1 q=4192256", bus.done, bus.quotOut);
         errors++;
      end
   endtask

   task automatic test_divzero();
      start_op(11'd1500, 11'd0);
      wait_done();
      vectors++;
      if (n !== 0 || busy_cnt !== 0) begin
         $display("FAIL divzero_lat: got n=%0d busy=%0d want n=0 busy=0", n, busy_cnt);
         errors++;
      end
      vectors++;
      if (bus.quotOut !== 22'h3FFFFF || bus.remOut !== 11'd0 || bus.sticky !== 1'b0 || bus.divZero !== 1'b1) begin
         $display("FAIL divzero_res: got q=%h r=%0d s=%b z=%b want q=3fffff r=0 s=0 z=1",
                  bus.quotOut, bus.remOut, bus.sticky, bus.divZero);
         errors++;
      end
   endtask

   task automatic test_ignore_start();
      start_op(11'd1536, 11'd1024);
      n        = 0;
      busy_cnt = 1;
      while (bus.done !== 1'b1 && n < 60) begin
         bus.divIn1 = 11'($urandom_range(0, 2047));
         bus.divIn2 = 11'($urandom_range(0, 2047));
         if (n == 10) begin
            bus.divIn1 = 11'd2047;
            bus.divIn2 = 11'd1;
            bus.start  = 1'b1;
         end else begin
            bus.start  = 1'b0;
         end
         @(negedge clock);
         n++;
      end
      bus.start = 1'b0;
      vectors++;
      if (n !== 22 || bus.quotOut !== 22'd3072 || bus.remOut !== 11'd0) begin
         $display("FAIL ignore_start: got n=%0d q=%0d r=%0d want n=22 q=3072 r=0",
                  n, bus.quotOut, bus.remOut);
         errors++;
      end
   endtask

   task automatic test_async_reset();
      start_op(11'd1536, 11'd1024);
      repeat (7) @(negedge clock);
      #2;
      resetN = 1'b0;
      #1;
      vectors++;
      if ({bus.quotOut, bus.remOut, bus.sticky, bus.divZero, bus.busy, bus.done} !== 36'd0) begin
         $display("FAIL async_reset: got q=%h r=%h s=%b z=%b b=%b d=%b want all 0",
                  bus.quotOut, bus.remOut, bus.sticky, bus.divZero, bus.busy, bus.done);
         errors++;
      end
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         $display("FAIL reset_idle: got b=%b d=%b want b=0 d=0", bus.busy, bus.done);
         errors++;
      end
      start_op(11'd1024, 11'd1024);
      wait_done();
      vectors++;
      if (n !== 22 || bus.quotOut !== 22'd2048) begin
         $display("FAIL post_reset_run: got n=%0d q=%0d want n=22 q=2048", n, bus.quotOut);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      start_op(11'd1536, 11'd1024);
      wait_done();
      vectors++;
      if (bus.quotOut !== 22'd3072) begin
         $display("FAIL b2b_first: got q=%0d want 3072", bus.quotOut);
         errors++;
      end
      // Leave a divide-by-zero result in DONE so the restart must clear divZero
      start_op(11'd5, 11'd0);
      start_op(11'd2047, 11'd1024);
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         $display("FAIL b2b_done_drop: got d=%b b=%b want d=0 b=1", bus.done, bus.busy);
         errors++;
      end
      wait_done();
      vectors++;
      if (n !== 22 || bus.quotOut !== 22'd4094 || bus.divZero !== 1'b0) begin
         $display("FAIL b2b_second: got n=%0d q=%0d z=%b want n=22 q=4094 z=0",
                  n, bus.quotOut, bus.divZero);
         errors++;
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_basic();
      test_divzero();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
